// File: rtl/vga_box_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_box_renderer
//  Purpose  : Two-stage pixel generator behind the 1024x768 timing driver.
//             Draws a screen border and a square that bounces off the edges,
//             moving once per frame on the falling edge of vertical sync.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_box_renderer #(
  parameter int          H_RES      = 1024,
  parameter int          V_RES      = 768,
  parameter int          BOX_SIZE   = 64,
  parameter int          STEP       = 4,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [11:0] hc_visible,
  input  logic [11:0] vc_visible,
  input  logic        pause,
  input  logic [11:0] box_rgb,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);

  localparam logic [11:0] c_STEP   = 12'(STEP);
  localparam logic [11:0] c_MIN    = 12'd1;
  localparam logic [11:0] c_X_MAX  = 12'(H_RES - BOX_SIZE);
  localparam logic [11:0] c_Y_MAX  = 12'(V_RES - BOX_SIZE);
  localparam logic [11:0] c_X_LAST = 12'(H_RES - 1);
  localparam logic [11:0] c_Y_LAST = 12'(V_RES - 1);
  localparam logic [11:0] c_BOX    = 12'(BOX_SIZE);

  // Stage-1 registers; r_vs1 doubles as the delayed vs_in for edge detection
  logic        r_hs1;
  logic        r_vs1;
  logic [11:0] r_hc1;
  logic [11:0] r_vc1;
  logic [11:0] r_rgb;
  logic        r_dir_x;
  logic        r_dir_y;

  logic        w_tick;
  logic [11:0] w_bx;
  logic [11:0] w_by;
  logic [10:0] w_nx;
  logic [10:0] w_ny;
  logic        w_ndx;
  logic        w_ndy;
  logic        w_active;
  logic        w_border;
  logic        w_in_box;
  logic [11:0] w_rgb;

  // Zero-extended positions so box+size and pos+step never overflow
  assign w_bx   = {1'b0, box_x};
  assign w_by   = {1'b0, box_y};
  assign w_tick = r_vs1 & ~vs_in;

  // Stage 1: capture sync and coordinates from the timing driver
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_hc1 <= '0;
      r_vc1 <= '0;
    end else begin
      r_hs1 <= hs_in;
      r_vs1 <= vs_in;
      r_hc1 <= hc_visible;
      r_vc1 <= vc_visible;
    end
  end

  // Next box position/direction per axis; clamps to the limit on a bounce
  always_comb begin
    w_nx  = box_x;
    w_ny  = box_y;
    w_ndx = r_dir_x;
    w_ndy = r_dir_y;
    if (r_dir_x) begin
      if (w_bx + c_STEP >= c_X_MAX) begin
        w_nx  = c_X_MAX[10:0];
        w_ndx = 1'b0;
      end else begin
        w_nx  = box_x + c_STEP[10:0];
      end
    end else begin
      if (w_bx <= c_MIN + c_STEP) begin
        w_nx  = c_MIN[10:0];
        w_ndx = 1'b1;
      end else begin
        w_nx  = box_x - c_STEP[10:0];
      end
    end
    if (r_dir_y) begin
      if (w_by + c_STEP >= c_Y_MAX) begin
        w_ny  = c_Y_MAX[10:0];
        w_ndy = 1'b0;
      end else begin
        w_ny  = box_y + c_STEP[10:0];
      end
    end else begin
      if (w_by <= c_MIN + c_STEP) begin
        w_ny  = c_MIN[10:0];
        w_ndy = 1'b1;
      end else begin
        w_ny  = box_y - c_STEP[10:0];
      end
    end
  end

  // Motion state advances only on an unpaused frame tick (inside vsync)
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      box_x   <= 11'd1;
      box_y   <= 11'd1;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_tick && !pause) begin
      box_x   <= w_nx;
      box_y   <= w_ny;
      r_dir_x <= w_ndx;
      r_dir_y <= w_ndy;
    end
  end

  // Colour select: blanking, then border, then box, then background
  always_comb begin
    w_active = (r_hc1 != 12'd0) && (r_vc1 != 12'd0);
    w_border = (r_hc1 == 12'd1) || (r_hc1 == c_X_LAST) ||
               (r_vc1 == 12'd1) || (r_vc1 == c_Y_LAST);
    w_in_box = (r_hc1 >= w_bx) && (r_hc1 < w_bx + c_BOX) &&
               (r_vc1 >= w_by) && (r_vc1 < w_by + c_BOX);
    w_rgb    = 12'h000;
    if (w_active) begin
      if (w_border)      w_rgb = BORDER_RGB;
      else if (w_in_box) w_rgb = box_rgb;
      else               w_rgb = BG_RGB;
    end
  end

  // Stage 2: register colour together with the matching sync pulses
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      r_rgb <= '0;
    end else begin
      hs    <= r_hs1;
      vs    <= r_vs1;
      r_rgb <= w_rgb;
    end
  end

  assign vga_r = r_rgb[11:8];
  assign vga_g = r_rgb[7:4];
  assign vga_b = r_rgb[3:0];

endmodule
`default_nettype wire
